// File: rtl/heap_feeder.sv
// rtl/heap_feeder.sv - sequences a record stream into the heap sorter and re-frames its sorted output
module heap_feeder #(
  parameter int DATA_WIDTH    = 32,
  parameter int KEY_WIDTH     = 16,
  parameter int NLEVELS       = 2,
  parameter int INIT_CYCLES   = 4,
  parameter int FLUSH_COUNT   = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] heap_din,
  output logic                  heap_en,
  output logic                  heap_init,
  input  logic [DATA_WIDTH-1:0] heap_dout,
  input  logic                  heap_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {IDLE, INIT, RUN, FLUSH, DRAIN} state_t;

  localparam int TW = $clog2(DRAIN_TIMEOUT + INIT_CYCLES + FLUSH_COUNT + 1);
  localparam logic [DATA_WIDTH-1:0] FLUSH_WORD =
    {2'b11, {(DATA_WIDTH-2-KEY_WIDTH){1'b0}}, {KEY_WIDTH{1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CNT_FORCE_LAST = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

  state_t               state, state_n;
  logic [TW-1:0]        tmr, tmr_n;
  logic [CNT_WIDTH-1:0] in_cnt, out_cnt, out_cnt_inc;
  logic                 start_ok, accept, drained, timed_out, out_take;
  logic                 unused_bits;

  assign unused_bits = ^{heap_dout[DATA_WIDTH-1:DATA_WIDTH-2], s_data[DATA_WIDTH-1:DATA_WIDTH-2], 1'(NLEVELS)};

  // a start landing on the done pulse is dropped so the source must retry
  assign start_ok    = (state == IDLE) && start && !done;
  assign accept      = (state == RUN) && s_valid;
  assign drained     = (out_cnt == in_cnt);
  assign timed_out   = (state == DRAIN) && !drained && (tmr == TW'(DRAIN_TIMEOUT-1));
  assign out_cnt_inc = out_cnt + 1'b1;
  assign out_take    = heap_valid && (out_cnt != in_cnt);
  assign busy        = (state != IDLE);

  always_comb begin
    state_n   = state;
    tmr_n     = tmr;
    s_ready   = 1'b0;
    heap_en   = 1'b0;
    heap_din  = '0;
    heap_init = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_n = INIT;
          tmr_n   = '0;
        end
      end
      INIT: begin
        heap_init = 1'b1;
        if (tmr == TW'(INIT_CYCLES-1)) begin
          state_n = RUN;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      RUN: begin
        s_ready = 1'b1;
        if (s_valid) begin
          heap_en  = 1'b1;
          heap_din = {2'b00, s_data[DATA_WIDTH-3:0]};
          if (s_last || in_cnt == CNT_FORCE_LAST) begin
            state_n = FLUSH;
            tmr_n   = '0;
          end
        end
      end
      FLUSH: begin
        heap_en  = 1'b1;
        heap_din = FLUSH_WORD;
        if (tmr == TW'(FLUSH_COUNT-1)) begin
          state_n = DRAIN;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      DRAIN: begin
        if (drained || timed_out) state_n = IDLE;
        else                      tmr_n   = tmr + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tmr     <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      done  <= (state == DRAIN) && drained;
      if (start_ok)       err <= 1'b0;
      else if (timed_out) err <= 1'b1;
      if (start_ok)    in_cnt <= '0;
      else if (accept) in_cnt <= in_cnt + 1'b1;
      if (start_ok) begin
        out_cnt <= '0;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else if (out_take) begin
        out_cnt <= out_cnt_inc;
        m_data  <= {2'b00, heap_dout[DATA_WIDTH-3:0]};
        m_valid <= 1'b1;
        m_last  <= (out_cnt_inc == in_cnt) && (state == FLUSH || state == DRAIN);
      end else begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/heap_feeder.md
# heap_feeder

Stream sequencer that drives the streaming `heap` sorter and collects its output.
- Accepts a record stream over a valid/ready handshake and initializes the heap.
- Pushes each record as a variable-tagged word, then injects flush tokens at end of stream to drain the remaining contents.
- Re-emits the heap's sorted output as a framed stream with last marker and done/error status.
- Sits between the upstream record source and the heap's `din/en/init` / `dout/valid` ports.

## Interface
Parameters:
- DATA_WIDTH, 32, heap word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the tag flag
- KEY_WIDTH, 16, key field width (bits [KEY_WIDTH-1:0])
- NLEVELS, 2, heap levels of the attached sorter
- INIT_CYCLES, 4, cycles `heap_init` is held high
- FLUSH_COUNT, 8, flush tokens injected after the last record; also the maximum record count for a fully sorted output
- CNT_WIDTH, 16, record/output counter width
- DRAIN_TIMEOUT, 64, cycles allowed after the final flush token before error

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sort job when idle
- s_data  in  DATA_WIDTH  input record; low KEY_WIDTH bits are the key
- s_valid  in  1  input record valid
- s_last  in  1  marks the final record of the job
- s_ready  out  1  block accepts a record this cycle
- heap_din  out  DATA_WIDTH  to heap `din`
- heap_en  out  1  to heap `en`
- heap_init  out  1  to heap `init`
- heap_dout  in  DATA_WIDTH  from heap `dout`
- heap_valid  in  1  from heap `valid`
- m_data  out  DATA_WIDTH  sorted output record, tag bits forced to 00
- m_valid  out  1  output record valid; no backpressure
- m_last  out  1  with m_valid on the job's final output record
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the job completes normally
- err  out  1  sticky drain timeout; cleared by the next accepted start or by rst

## Operation
- **FSM states:** IDLE, INIT, RUN, FLUSH, DRAIN.
- **IDLE → INIT:** on `start`. Clears in_cnt, out_cnt and err. `start` in any other state is ignored.
- **INIT:**
  - `heap_init` = 1 for exactly INIT_CYCLES cycles; `heap_en` = 0.
  - Then go to RUN.
- **RUN:**
  - `s_ready` = 1.
  - On `s_valid && s_ready`: `heap_din` = {2'b00, s_data[DATA_WIDTH-3:0]}, `heap_en` = 1, in_cnt increments. The incoming flag bits are discarded.
  - When the accepted record has `s_last`, or in_cnt reaches 2^CNT_WIDTH-1 (the record is forced last), go to FLUSH.
  - If no record is accepted: `heap_en` = 0.
- **FLUSH:**
  - `s_ready` = 0.
  - Issue FLUSH_COUNT consecutive cycles of `heap_en` = 1 with `heap_din` = {2'b11, zeros, KEY_WIDTH ones}.
  - Then go to DRAIN.
- **DRAIN:**
  - `heap_en` = 0. A timeout counter runs.
  - When out_cnt == in_cnt: pulse `done`, go to IDLE.
  - When the counter reaches DRAIN_TIMEOUT: set `err`, go to IDLE with no `done`.
- **Output path (all states):**
  - On `heap_valid`: register `m_data` = {2'b00, heap_dout[DATA_WIDTH-3:0]}, `m_valid` = 1, out_cnt increments.
  - `m_last` = 1 when the incremented out_cnt equals in_cnt and the state is FLUSH or DRAIN.
  - `heap_valid` after out_cnt == in_cnt is dropped.
- **Ordering:**
  - Output is in ascending key order when in_cnt ≤ FLUSH_COUNT.
  - Beyond that, output is sorted runs (replacement-selection behaviour).
  - Equal keys: order unspecified; all records are preserved.

## Timing
- **Reset values:** all outputs 0; state IDLE; counters 0.
- **Reset mid-job:** returns to IDLE immediately. The heap is re-initialized only by the next INIT.
- **Latency:**
  - `start` → `heap_init` high on the next cycle.
  - Last INIT cycle → `s_ready` high on the next cycle.
  - Accepted record → `heap_en` is combinational with the handshake; `heap_din` and `heap_en` are valid in the same cycle as acceptance.
  - `heap_valid` → `m_valid` one cycle later.
- **Back-to-back:** one record per cycle in RUN.
- **FSM timing:**
  - The FLUSH state follows the s_last acceptance cycle with zero bubble.
  - `done` is asserted in the cycle after the final `m_valid`/`m_last` (out_cnt == in_cnt observed).
  - `busy` deasserts in the same cycle as `done`.
- **Simultaneous events:** `start` coincident with `done` is ignored; the source must retry.

## Test plan
- Reset then start: INIT_CYCLES=4. Expect `heap_init` high exactly 4 cycles, `s_ready` rising on cycle 6 after start; all outputs 0 during reset.
- Push keys 5, 3, 9, 1 (last on 1) back-to-back. Expect `m_data` keys 1, 3, 5, 9, `m_last` on 9, `done` one cycle later, 8 flush cycles with `heap_din` = 0xC000FFFF.
- Input with flag bits 2'b11 set (s_data = 0xC0000007). Expect `heap_din` = 0x00000007 and output key 7 with flag 00.
- Single record key 0x1234 with s_last. Expect one output, `m_valid` and `m_last` both high, `done` pulse, in_cnt = out_cnt = 1.
- Tie `heap_valid` low (heap model stubbed). Expect `err` = 1 after 64 DRAIN cycles, no `done`, `busy` = 0, `err` cleared by the next start.
- Assert rst during FLUSH. Expect immediate IDLE, all outputs 0; a new job of keys 2, 1 sorts to 1, 2.
